// File: rtl/cla_pkg.sv
// Shared types and carry-lookahead helper for the nibble-grouped add/sub datapath.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 8;
    localparam int unsigned CLA_HALF  = CLA_WIDTH / 2;

    typedef logic [CLA_WIDTH-1:0] operand_t;
    typedef logic [CLA_WIDTH:0]   result_t;
    typedef logic [CLA_HALF-1:0]  half_t;

    // Stage-1 payload: finished low half plus the high-half operands still to add.
    typedef struct packed {
        half_t a_hi;
        half_t bn_hi;
        half_t lo;
        logic  carry;
    } s1_t;

    // Carries into every bit of a group, each expanded as a flat sum of products.
    function automatic logic [CLA_HALF:0] cla_group(input half_t p, input half_t g, input logic cin);
        logic [CLA_HALF:0] c;
        logic              prop;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(CLA_HALF); i++) begin
            c[i+1] = g[i];
            prop   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prop & g[j]);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & cin);
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_nibble_add.sv
// Combinational half-width carry-lookahead adder with group propagate/generate.
module cla_nibble_add
    import cla_pkg::*;
(
    input  logic [CLA_HALF-1:0] a,
    input  logic [CLA_HALF-1:0] b,
    input  logic                cin,
    output logic [CLA_HALF-1:0] s,
    output logic                cout,
    output logic                gp,
    output logic                gg
);

    half_t             p;
    half_t             g;
    logic [CLA_HALF:0] c;
    logic              gen_acc;

    always_comb begin
        p       = a ^ b;
        g       = a & b;
        c       = cla_group(p, g, cin);
        s       = p ^ c[CLA_HALF-1:0];
        cout    = c[CLA_HALF];
        gp      = &p;
        // Group generate: carry out of the group with no carry in.
        gen_acc = 1'b0;
        for (int i = 0; i < int'(CLA_HALF); i++) begin
            gen_acc = g[i] | (p[i] & gen_acc);
        end
        gg      = gen_acc;
    end

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage valid/ready subtractor: diff = A - B - bIn, MSB of diff is borrow-out.
// Optional signed-overflow output enabled by defining CLA_SUB_OVF_EN.
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bIn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   diff,
    output logic             out_valid,
`ifdef CLA_SUB_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    localparam int unsigned HALF = WIDTH / 2;

    logic [WIDTH-1:0] b_n;
    logic [HALF-1:0]  lo_s;
    logic             lo_cout;
    logic             lo_gp;
    logic             lo_gg;
    logic [HALF-1:0]  hi_s;
    logic             hi_cout;
    logic             hi_gp;
    logic             hi_gg;

    logic             s1_valid;
    s1_t              s1_q;
    s1_t              s1_d;
    logic             s1_advance;
    logic             accept;
    logic [WIDTH:0]   diff_d;
`ifdef CLA_SUB_OVF_EN
    logic             ovf_d;
`endif

    // Group P/G are for callers chaining nibbles; the two-stage split uses ripple-out carries.
    logic grp_unused;
    assign grp_unused = ^{lo_gp, lo_gg, hi_gp, hi_gg};

    // Subtraction as A + ~B with carry-in = ~bIn.
    assign b_n = ~B;

    cla_nibble_add u_lo (
        .a    (A[HALF-1:0]),
        .b    (b_n[HALF-1:0]),
        .cin  (~bIn),
        .s    (lo_s),
        .cout (lo_cout),
        .gp   (lo_gp),
        .gg   (lo_gg)
    );

    cla_nibble_add u_hi (
        .a    (s1_q.a_hi),
        .b    (s1_q.bn_hi),
        .cin  (s1_q.carry),
        .s    (hi_s),
        .cout (hi_cout),
        .gp   (hi_gp),
        .gg   (hi_gg)
    );

    // Handshake and next-state payloads.
    always_comb begin
        s1_advance  = s1_valid && (!out_valid || out_ready);
        in_ready    = !s1_valid || s1_advance;
        accept      = in_valid && in_ready;

        s1_d.a_hi   = A[WIDTH-1:HALF];
        s1_d.bn_hi  = b_n[WIDTH-1:HALF];
        s1_d.lo     = lo_s;
        s1_d.carry  = lo_cout;

        diff_d      = {~hi_cout, hi_s, s1_q.lo};
`ifdef CLA_SUB_OVF_EN
        // Sign of B is the complement of the stored ~B sign bit.
        ovf_d       = (s1_q.a_hi[HALF-1] == s1_q.bn_hi[HALF-1]) &&
                      (hi_s[HALF-1] != s1_q.a_hi[HALF-1]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
`ifdef CLA_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                s1_q     <= s1_d;
                s1_valid <= 1'b1;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end

            if (s1_advance) begin
                out_valid <= 1'b1;
                diff      <= diff_d;
`ifdef CLA_SUB_OVF_EN
                ovf       <= ovf_d;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: directed table, multi-cycle handshake sequences, random scoreboard.
module tb_cla_sub_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       bIn;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] diff;
    logic       out_valid;
    logic       out_ready;
`ifdef CLA_SUB_OVF_EN
    logic       ovf;
`endif

    always #5 clk = ~clk;

    cla_sub_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .bIn       (bIn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .out_valid (out_valid),
`ifdef CLA_SUB_OVF_EN
        .ovf       (ovf),
`endif
        .out_ready (out_ready)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [8:0] d;
        logic       o;
        int         edge_no;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [8:0] d;
        logic       o;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, borrow when the true difference is negative.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin, input int e);
        exp_t x;
        int   r;
        int   sr;
        r         = int'(a) - int'(b) - int'(bin);
        sr        = int'($signed(a)) - int'($signed(b)) - int'(bin);
        x.d       = {(r < 0), 8'(r)};
        x.o       = (sr < -128) || (sr > 127);
        x.edge_no = e;
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampling mid-cycle while everything is stable.
    logic       prev_hold = 1'b0;
    logic [8:0] prev_diff = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_valid", 9'(out_valid), 9'd1);
                check("hold_diff", diff, prev_diff);
            end
            check("sb_depth_le2", 9'(sb.size() <= 2), 9'd1);
            check("mon_out_valid", 9'(out_valid),
                  9'((sb.size() != 0) && ((cyc - sb[0].edge_no) >= 1)));
            check("mon_in_ready", 9'(in_ready), 9'(!(sb.size() >= 2 && !out_ready)));
            if (out_valid && sb.size() != 0) begin
                check("mon_diff", diff, sb[0].d);
`ifdef CLA_SUB_OVF_EN
                check("mon_ovf", 9'(ovf), 9'(sb[0].o));
`endif
            end
            if (rst) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
                if (in_valid && in_ready) sb.push_back(model(A, B, bIn, cyc + 1));
            end
            prev_hold = out_valid && !out_ready && !rst;
            prev_diff = diff;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi);
        in_valid = v;
        A        = a;
        B        = b;
        bIn      = bi;
    endtask

    initial begin
        logic       rdy;
        logic [8:0] got[$];
        logic [8:0] stall_exp[3];
        int         k;
        int         iters;

        vecs[0]  = '{8'd255, 8'd122, 1'b0, 9'h085, 1'b0};
        vecs[1]  = '{8'd12,  8'd124, 1'b0, 9'h190, 1'b0};
        vecs[2]  = '{8'd3,   8'd10,  1'b1, 9'h1F8, 1'b0};
        vecs[3]  = '{8'd200, 8'd30,  1'b0, 9'h0AA, 1'b0};
        vecs[4]  = '{8'd23,  8'd100, 1'b0, 9'h1B3, 1'b0};
        vecs[5]  = '{8'd0,   8'd0,   1'b1, 9'h1FF, 1'b0};
        vecs[6]  = '{8'd255, 8'd255, 1'b0, 9'h000, 1'b0};
        vecs[7]  = '{8'd0,   8'd255, 1'b0, 9'h101, 1'b0};
        vecs[8]  = '{8'd255, 8'd0,   1'b1, 9'h0FE, 1'b0};
        vecs[9]  = '{8'h80,  8'h01,  1'b0, 9'h07F, 1'b1};
        vecs[10] = '{8'h05,  8'h03,  1'b0, 9'h002, 1'b0};
        vecs[11] = '{8'd127, 8'd255, 1'b0, 9'h180, 1'b1};
        vecs[12] = '{8'd100, 8'd100, 1'b1, 9'h1FF, 1'b0};

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check("reset_out_valid", 9'(out_valid), 9'd0);
        check("reset_diff", diff, 9'd0);
        check("reset_in_ready", 9'(in_ready), 9'd1);
        mon_en = 1'b1;

        // Isolated vectors: two-edge latency, single-cycle out_valid.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_not_early", i), 9'(out_valid), 9'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 9'(out_valid), 9'd1);
            check($sformatf("vec%0d_diff", i), diff, vecs[i].d);
`ifdef CLA_SUB_OVF_EN
            check($sformatf("vec%0d_ovf", i), 9'(ovf), 9'(vecs[i].o));
`endif
            tick();
            check($sformatf("vec%0d_one_shot", i), 9'(out_valid), 9'd0);
        end

        // Back-to-back operands come out on consecutive cycles.
        drive(1'b1, 8'd3, 8'd10, 1'b1);
        tick();
        drive(1'b1, 8'd200, 8'd30, 1'b0);
        tick();
        in_valid = 1'b0;
        check("b2b_first_valid", 9'(out_valid), 9'd1);
        check("b2b_first_diff", diff, 9'h1F8);
        tick();
        check("b2b_second_valid", 9'(out_valid), 9'd1);
        check("b2b_second_diff", diff, 9'h0AA);
        tick();
        check("b2b_idle", 9'(out_valid), 9'd0);

        // Backpressure: two results held, third offer refused, then drained in order.
        stall_exp[0] = 9'h1B3;
        stall_exp[1] = 9'h0AA;
        stall_exp[2] = 9'h1F9;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (k == 0) drive(1'b1, 8'd23, 8'd100, 1'b0);
            else if (k == 1) drive(1'b1, 8'd200, 8'd30, 1'b0);
            else drive(1'b1, 8'd3, 8'd10, 1'b0);
            rdy = in_ready;
            tick();
            if (rdy && k < 3) k++;
        end
        check("stall_accepted", 9'(k), 9'd2);
        check("stall_in_ready", 9'(in_ready), 9'd0);
        check("stall_out_valid", 9'(out_valid), 9'd1);
        check("stall_diff", diff, 9'h1B3);
        out_ready = 1'b1;
        iters = 0;
        for (int c = 0; c < 10 && got.size() < 3; c++) begin
            rdy = in_valid && in_ready;
            if (out_valid) got.push_back(diff);
            tick();
            iters++;
            if (rdy) in_valid = 1'b0;
        end
        check("drain_count", 9'(got.size()), 9'd3);
        check("drain_no_bubble", 9'(iters), 9'd3);
        if (got.size() == 3) begin
            for (int i = 0; i < 3; i++) check($sformatf("drain_order%0d", i), got[i], stall_exp[i]);
        end
        tick();
        check("drain_idle", 9'(out_valid), 9'd0);

        // Reset with an operand in flight discards it.
        drive(1'b1, 8'd200, 8'd30, 1'b0);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 9'(out_valid), 9'd0);
        check("midrst_diff", diff, 9'd0);
        check("midrst_in_ready", 9'(in_ready), 9'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("midrst_no_stale%0d", c), 9'(out_valid), 9'd0);
        end

        // Random traffic with random backpressure, checked by the scoreboard.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
        check("final_drained", 9'(sb.size()), 9'd0);
        tick();
        check("final_idle", 9'(out_valid), 9'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
